// File: rtl/switch_perf_pkg.sv
// Shared types for the switch performance monitor: read-port selector encoding.
package switch_perf_pkg;

    typedef enum logic [2:0] {
        PERF_SEL_PKTS    = 3'd0,
        PERF_SEL_LAT_SUM = 3'd1,
        PERF_SEL_LAT_MAX = 3'd2,
        PERF_SEL_ACTIVE  = 3'd3,
        PERF_SEL_FLITS   = 3'd4,
        PERF_SEL_OUT_BLK = 3'd5
    } perf_sel_t;

endpackage

// File: rtl/perf_sat_accum.sv
// Saturating accumulator with a shadow copy; MAX_MODE turns it into a running maximum.
module perf_sat_accum #(
    parameter int W        = 32,
    parameter bit MAX_MODE = 1'b0
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         snap_clr,
    input  logic [W-1:0] add,
    output logic [W-1:0] live,
    output logic [W-1:0] shadow
);

    logic [W-1:0] live_q, live_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic [W:0]   sum_w;
    logic [W-1:0] nxt;

    always_comb begin
        sum_w = {1'b0, live_q} + {1'b0, add};
        if (MAX_MODE) begin
            nxt = (add > live_q) ? add : live_q;
        end else begin
            nxt = sum_w[W] ? {W{1'b1}} : sum_w[W-1:0];
        end
        live_d   = nxt;
        shadow_d = shadow_q;
        if (clr) begin
            live_d   = '0;
            shadow_d = '0;
        end else if (snap_clr) begin
            // shadow captures this cycle's update too
            shadow_d = nxt;
            live_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            live_q   <= '0;
            shadow_q <= '0;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end

    assign live   = live_q;
    assign shadow = shadow_q;

endmodule

// File: rtl/switch_perf_monitor.sv
// Per-switch performance monitor: per-channel episode/flit counters, per-outport
// credit-block counters, optional sampling window with shadow snapshot, indexed read port.
module switch_perf_monitor
    import switch_perf_pkg::*;
#(
    parameter int NUM_CH       = 8,
    parameter int NUM_OUTPORTS = 4,
    parameter int CNT_W        = 32,
    parameter int LAT_W        = 16,
    parameter int WIN_W        = 20,
    localparam int IDX_W = $clog2((NUM_CH > NUM_OUTPORTS) ? NUM_CH : NUM_OUTPORTS)
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       ch_busy,
    input  logic [NUM_CH-1:0]       ch_active,
    input  logic [NUM_CH-1:0]       ch_flit,
    input  logic [NUM_OUTPORTS-1:0] out_blocked,
    input  logic [WIN_W-1:0]        window_len,
    output logic                    window_done,
    input  logic                    rd_en,
    input  logic [2:0]              rd_sel,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic                    rd_valid,
    output logic [CNT_W-1:0]        rd_data
);

    logic              en_eff, win_on, snap;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic              window_done_q, window_done_d;
    logic [NUM_CH-1:0] busy_q, fe;
    logic [LAT_W-1:0]  ep_lat_q [NUM_CH];
    logic [LAT_W-1:0]  ep_lat_d [NUM_CH];
    logic              rd_valid_q;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;

    logic [CNT_W-1:0] pkts_l [NUM_CH], pkts_s [NUM_CH];
    logic [CNT_W-1:0] lsum_l [NUM_CH], lsum_s [NUM_CH];
    logic [LAT_W-1:0] lmax_l [NUM_CH], lmax_s [NUM_CH];
    logic [CNT_W-1:0] act_l  [NUM_CH], act_s  [NUM_CH];
    logic [CNT_W-1:0] flit_l [NUM_CH], flit_s [NUM_CH];
    logic [CNT_W-1:0] blk_l  [NUM_OUTPORTS], blk_s [NUM_OUTPORTS];

    assign en_eff = enable & ~clear;
    assign win_on = (window_len != '0);
    // >= rather than == so a shrunk window_len snapshots on the next enabled cycle
    assign snap   = en_eff & win_on & (win_cnt_q >= window_len - WIN_W'(1));

    always_comb begin
        win_cnt_d     = win_cnt_q;
        window_done_d = snap;
        if (clear || !win_on || snap) begin
            win_cnt_d = '0;
        end else if (enable) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ep_lat_d[c] = ep_lat_q[c];
            if (!ch_busy[c] || clear) begin
                ep_lat_d[c] = '0;
            end else if (enable && (ep_lat_q[c] != {LAT_W{1'b1}})) begin
                ep_lat_d[c] = ep_lat_q[c] + LAT_W'(1);
            end
        end
        fe = busy_q & ~ch_busy & {NUM_CH{en_eff}};
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        perf_sat_accum #(.W(CNT_W)) u_pkts (
            .clk(clk), .nrst(nrst), .clr(clear), .snap_clr(snap),
            .add(CNT_W'(fe[c])), .live(pkts_l[c]), .shadow(pkts_s[c]));
        perf_sat_accum #(.W(CNT_W)) u_lsum (
            .clk(clk), .nrst(nrst), .clr(clear), .snap_clr(snap),
            .add(fe[c] ? CNT_W'(ep_lat_q[c]) : '0), .live(lsum_l[c]), .shadow(lsum_s[c]));
        perf_sat_accum #(.W(LAT_W), .MAX_MODE(1'b1)) u_lmax (
            .clk(clk), .nrst(nrst), .clr(clear), .snap_clr(snap),
            .add(fe[c] ? ep_lat_q[c] : '0), .live(lmax_l[c]), .shadow(lmax_s[c]));
        perf_sat_accum #(.W(CNT_W)) u_act (
            .clk(clk), .nrst(nrst), .clr(clear), .snap_clr(snap),
            .add(CNT_W'(en_eff & ch_active[c])), .live(act_l[c]), .shadow(act_s[c]));
        perf_sat_accum #(.W(CNT_W)) u_flit (
            .clk(clk), .nrst(nrst), .clr(clear), .snap_clr(snap),
            .add(CNT_W'(en_eff & ch_flit[c])), .live(flit_l[c]), .shadow(flit_s[c]));
    end

    for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_out
        perf_sat_accum #(.W(CNT_W)) u_blk (
            .clk(clk), .nrst(nrst), .clr(clear), .snap_clr(snap),
            .add(CNT_W'(en_eff & out_blocked[o])), .live(blk_l[o]), .shadow(blk_s[o]));
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(rd_idx) == i) begin
                    case (rd_sel)
                        PERF_SEL_PKTS:    rd_data_d = win_on ? pkts_s[i] : pkts_l[i];
                        PERF_SEL_LAT_SUM: rd_data_d = win_on ? lsum_s[i] : lsum_l[i];
                        PERF_SEL_LAT_MAX: rd_data_d = CNT_W'(win_on ? lmax_s[i] : lmax_l[i]);
                        PERF_SEL_ACTIVE:  rd_data_d = win_on ? act_s[i] : act_l[i];
                        PERF_SEL_FLITS:   rd_data_d = win_on ? flit_s[i] : flit_l[i];
                        default:          ;
                    endcase
                end
            end
            for (int o = 0; o < NUM_OUTPORTS; o++) begin
                if ((int'(rd_idx) == o) && (rd_sel == PERF_SEL_OUT_BLK)) begin
                    rd_data_d = win_on ? blk_s[o] : blk_l[o];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            win_cnt_q     <= '0;
            window_done_q <= 1'b0;
            busy_q        <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            for (int c = 0; c < NUM_CH; c++) ep_lat_q[c] <= '0;
        end else begin
            win_cnt_q     <= win_cnt_d;
            window_done_q <= window_done_d;
            busy_q        <= ch_busy;
            rd_valid_q    <= rd_en;
            rd_data_q     <= rd_data_d;
            for (int c = 0; c < NUM_CH; c++) ep_lat_q[c] <= ep_lat_d[c];
        end
    end

    assign window_done = window_done_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_switch_perf_monitor.sv
// Scoreboarded bench for switch_perf_monitor using a small configuration (4-bit counters).
module tb_switch_perf_monitor;
    import switch_perf_pkg::*;

    localparam int NUM_CH = 6;
    localparam int NUM_OUTPORTS = 4;
    localparam int CNT_W = 4;
    localparam int LAT_W = 4;
    localparam int WIN_W = 8;
    localparam int IDX_W = $clog2((NUM_CH > NUM_OUTPORTS) ? NUM_CH : NUM_OUTPORTS);

    logic                    clk = 1'b0;
    logic                    nrst;
    logic                    enable;
    logic                    clear;
    logic [NUM_CH-1:0]       ch_busy;
    logic [NUM_CH-1:0]       ch_active;
    logic [NUM_CH-1:0]       ch_flit;
    logic [NUM_OUTPORTS-1:0] out_blocked;
    logic [WIN_W-1:0]        window_len;
    logic                    window_done;
    logic                    rd_en;
    logic [2:0]              rd_sel;
    logic [IDX_W-1:0]        rd_idx;
    logic                    rd_valid;
    logic [CNT_W-1:0]        rd_data;

    int n_vec = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_q[$];
    string            tag_q[$];

    switch_perf_monitor #(
        .NUM_CH(NUM_CH), .NUM_OUTPORTS(NUM_OUTPORTS), .CNT_W(CNT_W),
        .LAT_W(LAT_W), .WIN_W(WIN_W)
    ) dut (
        .clk(clk), .nrst(nrst), .enable(enable), .clear(clear),
        .ch_busy(ch_busy), .ch_active(ch_active), .ch_flit(ch_flit),
        .out_blocked(out_blocked), .window_len(window_len), .window_done(window_done),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [2:0] sel, input int idx, input logic [CNT_W-1:0] exp,
                           input string tag);
        rd_en  = 1'b1;
        rd_sel = sel;
        rd_idx = IDX_W'(idx);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick;
        rd_en = 1'b0;
        check_val({tag, "_vld"}, 32'(rd_valid), 1);
        check_val(tag_q.pop_front(), 32'(rd_data), 32'(exp_q.pop_front()));
    endtask

    task automatic episode(input int ch, input int len);
        ch_busy[ch] = 1'b1;
        repeat (len) tick;
        ch_busy[ch] = 1'b0;
        tick;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick;
            cnt++;
        end while (!window_done && cnt < 40);
    endtask

    int cnt;

    initial begin
        nrst = 1'b0; enable = 1'b1; clear = 1'b0;
        ch_busy = '0; ch_active = '0; ch_flit = '0; out_blocked = '0;
        window_len = '0; rd_en = 1'b0; rd_sel = '0; rd_idx = '0;
        #12;
        check_val("rst_done", 32'(window_done), 0);
        check_val("rst_vld", 32'(rd_valid), 0);
        check_val("rst_data", 32'(rd_data), 0);
        tick;
        nrst = 1'b1;
        tick;

        // single 5-cycle episode on ch2, free-running
        episode(2, 5);
        do_read(PERF_SEL_PKTS, 2, 1, "t1_pkts");
        do_read(PERF_SEL_LAT_SUM, 2, 5, "t1_lsum");
        do_read(PERF_SEL_LAT_MAX, 2, 5, "t1_lmax");

        // two episodes and four flits on ch0
        episode(0, 3);
        tick;
        episode(0, 7);
        for (int i = 0; i < 4; i++) begin
            ch_flit[0] = 1'b1; tick;
            ch_flit[0] = 1'b0; tick;
        end
        do_read(PERF_SEL_PKTS, 0, 2, "t2_pkts");
        do_read(PERF_SEL_LAT_MAX, 0, 7, "t2_lmax");
        do_read(PERF_SEL_FLITS, 0, 4, "t2_flits");
        do_read(PERF_SEL_LAT_SUM, 0, 10, "t2_lsum");
        tick;
        check_val("hold_vld", 32'(rd_valid), 0);
        check_val("hold_data", 32'(rd_data), 10);

        // out-of-range reads, each after a nonzero read
        do_read(PERF_SEL_FLITS, 0, 4, "t6_pre1");
        do_read(PERF_SEL_PKTS, NUM_CH, 0, "t6_idx_oor");
        do_read(PERF_SEL_LAT_MAX, 0, 7, "t6_pre2");
        do_read(3'd7, 0, 0, "t6_sel7");
        do_read(PERF_SEL_PKTS, 2, 1, "t6_pre3");
        do_read(PERF_SEL_OUT_BLK, NUM_OUTPORTS, 0, "t6_port_oor");
        do_read(3'd6, 0, 0, "t6_sel6");

        // saturation: 20 active cycles and a 20-cycle episode into 4-bit counters
        ch_active[0] = 1'b1;
        repeat (20) tick;
        ch_active[0] = 1'b0;
        episode(1, 20);
        do_read(PERF_SEL_ACTIVE, 0, 15, "t4_act_sat");
        do_read(PERF_SEL_LAT_SUM, 1, 15, "t4_lsum_sat");
        do_read(PERF_SEL_LAT_MAX, 1, 15, "t4_lmax_sat");

        // window of 10 with out_blocked[1] held
        clear = 1'b1; tick; clear = 1'b0;
        window_len = 8'd10;
        out_blocked[1] = 1'b1;
        wait_done(cnt);
        check_val("t3_period1", 32'(cnt), 10);
        tick;
        check_val("t3_pulse_w", 32'(window_done), 0);
        wait_done(cnt);
        check_val("t3_period2", 32'(cnt), 9);
        repeat (3) tick;
        out_blocked[1] = 1'b0;
        do_read(PERF_SEL_OUT_BLK, 1, 10, "t3_shadow");
        window_len = '0;
        do_read(PERF_SEL_OUT_BLK, 1, 3, "t3_live");

        // clear: read serviced pre-clear, then clear lands on the snapshot cycle
        clear = 1'b1;
        do_read(PERF_SEL_OUT_BLK, 1, 3, "t5_preclr_rd");
        clear = 1'b0;
        window_len = 8'd4;
        out_blocked[1] = 1'b1;
        repeat (3) tick;
        clear = 1'b1; tick;
        clear = 1'b0; out_blocked[1] = 1'b0;
        check_val("t5_done0", 32'(window_done), 0);
        tick;
        check_val("t5_done1", 32'(window_done), 0);
        do_read(PERF_SEL_OUT_BLK, 1, 0, "t5_shadow");
        window_len = '0;
        do_read(PERF_SEL_OUT_BLK, 1, 0, "t5_live");

        // falling edge and activity while disabled are dropped
        ch_busy[3] = 1'b1;
        repeat (2) tick;
        enable = 1'b0; ch_busy[3] = 1'b0; ch_active[0] = 1'b1;
        repeat (3) tick;
        enable = 1'b1; ch_active[0] = 1'b0;
        tick;
        do_read(PERF_SEL_PKTS, 3, 0, "t5_dis_pkts");
        do_read(PERF_SEL_ACTIVE, 0, 0, "t5_dis_act");
        episode(3, 2);
        do_read(PERF_SEL_PKTS, 3, 1, "t5_en_pkts");
        do_read(PERF_SEL_LAT_SUM, 3, 2, "t5_en_lsum");

        // async reset in the middle of an episode
        ch_busy[4] = 1'b1;
        repeat (3) tick;
        nrst = 1'b0;
        #3;
        check_val("t6_rst_vld", 32'(rd_valid), 0);
        check_val("t6_rst_data", 32'(rd_data), 0);
        check_val("t6_rst_done", 32'(window_done), 0);
        tick;
        ch_busy[4] = 1'b0;
        nrst = 1'b1;
        tick;
        do_read(PERF_SEL_PKTS, 4, 0, "t6_rst_pkts");
        do_read(PERF_SEL_LAT_SUM, 3, 0, "t6_rst_lsum");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
